pwm_cfg_scheduler: RTL and testbench

- Shared configuration engine for N_CH PWM output channels.
- Each channel raises a level request. The block arbitrates round-robin, latches that channel's pwm_freq/duty plus the common clk_freq, and computes period = clk_freq / pwm_freq on one shared iterative divider.
- It then derives high/low widths and writes them into per-channel width registers that drive the channels' pwm_output instances.
- One division in flight at a time; each request is answered with a one-cycle ack.

---
 rtl/pwm_cfg_scheduler_if.sv | 27 ++
 rtl/pwm_cfg_scheduler.sv | 176 +++++++++++++++++
 tb/tb_pwm_cfg_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_scheduler_if.sv
// Request/configuration bus between the PWM channels and the shared
// width-computation engine; master drives requests, slave answers.
interface pwm_cfg_scheduler_if #(
    parameter int N_CH = 4,
    parameter int W    = 32
);
    logic [W-1:0]      clk_freq;
    logic [N_CH-1:0]   req;
    logic [W*N_CH-1:0] pwm_freq;
    logic [16*N_CH-1:0] duty;
    logic [N_CH-1:0]   ack;
    logic [N_CH-1:0]   err;
    logic [N_CH-1:0]   upd;
    logic              busy;
    logic [W*N_CH-1:0] high_width;
    logic [W*N_CH-1:0] low_width;

    modport master (
        output clk_freq, req, pwm_freq, duty,
        input  ack, err, upd, busy, high_width, low_width
    );

    modport slave (
        input  clk_freq, req, pwm_freq, duty,
        output ack, err, upd, busy, high_width, low_width
    );
endinterface

// File: rtl/pwm_cfg_scheduler.sv
// Round-robin configuration engine: one shared restoring divider turns
// clk_freq/pwm_freq into a period and splits it into high/low widths.
module pwm_cfg_scheduler #(
    parameter int N_CH      = 4,
    parameter int W         = 32,
    parameter int DEF_WIDTH = 100
) (
    input logic clk,
    input logic rst,
    pwm_cfg_scheduler_if.slave bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int KW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        DIV,
        MUL,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] ptr;
    logic [CW-1:0] grant;
    logic [CW-1:0] pick;
    logic [CW-1:0] sel;
    logic          any_req;

    // dvd holds the dividend and is shifted into the quotient in place
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [W-1:0]  rem;
    logic [15:0]   dty;
    logic [KW-1:0] cnt;
    logic          fail;

    logic [W-1:0]  freq_sel;
    logic [15:0]   duty_sel;
    logic [W:0]    rem_sh;
    logic          ge;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  dvd_nxt;
    logic [W+15:0] prod;
    logic [W-1:0]  high;
    logic [W-1:0]  low;

    logic [W-1:0]  hw [N_CH];
    logic [W-1:0]  lw [N_CH];

    logic [N_CH-1:0] ack_v;
    logic [N_CH-1:0] err_v;
    logic [N_CH-1:0] upd_v;

    assign freq_sel = bus.pwm_freq[int'(grant)*W +: W];
    assign duty_sel = bus.duty[int'(grant)*16 +: 16];

    assign rem_sh  = {rem, dvd[W-1]};
    assign ge      = rem_sh >= {1'b0, dvs};
    assign rem_nxt = W'(ge ? rem_sh - {1'b0, dvs} : rem_sh);
    assign dvd_nxt = {dvd[W-2:0], ge};

    assign prod = (W+16)'(dvd) * (W+16)'(dty);
    assign high = W'(prod >> 16);
    assign low  = dvd - high;

    // First requesting channel after the round-robin pointer, wrapping
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        sel     = '0;
        for (int k = 1; k <= N_CH; k++) begin
            sel = CW'((int'(ptr) + k) % N_CH);
            if (!any_req && bus.req[sel]) begin
                any_req = 1'b1;
                pick    = sel;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (any_req) state_nxt = LATCH;
            LATCH: state_nxt = (freq_sel == '0) ? WRITE : DIV;
            DIV:   if (cnt == KW'(W-1)) state_nxt = MUL;
            MUL:   state_nxt = WRITE;
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, operand latch, divider iteration and error tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= CW'(N_CH-1);
            grant <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            dty   <= '0;
            cnt   <= '0;
            fail  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    fail <= 1'b0;
                    if (any_req) grant <= pick;
                end
                LATCH: begin
                    dvd  <= bus.clk_freq;
                    dvs  <= freq_sel;
                    dty  <= duty_sel;
                    rem  <= '0;
                    cnt  <= '0;
                    fail <= (freq_sel == '0);
                end
                DIV: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                end
                MUL: begin
                    if (dvd == '0) fail <= 1'b1;
                end
                WRITE: begin
                    ptr <= grant;
                end
                default: ;
            endcase
        end
    end

    // Width registers: loaded on MUL->WRITE so they show during WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                hw[i] <= W'(DEF_WIDTH);
                lw[i] <= W'(DEF_WIDTH);
            end
        end else if (state == MUL && dvd != '0) begin
            hw[grant] <= high;
            lw[grant] <= low;
        end
    end

    // Completion pulses for the granted channel
    always_comb begin
        ack_v = '0;
        err_v = '0;
        upd_v = '0;
        if (state == WRITE) begin
            ack_v[grant] = 1'b1;
            if (fail) err_v[grant] = 1'b1;
            else      upd_v[grant] = 1'b1;
        end
    end

    assign bus.ack  = ack_v;
    assign bus.err  = err_v;
    assign bus.upd  = upd_v;
    assign bus.busy = (state != IDLE);

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign bus.high_width[g*W +: W] = hw[g];
        assign bus.low_width[g*W +: W]  = lw[g];
    end
endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler: directed cases with literal results plus
// randomized requests compared every cycle against a transaction model.
module tb_pwm_cfg_scheduler;
    localparam int N_CH = 4;
    localparam int W    = 32;
    localparam int DEF  = 100;

    logic clk;
    logic rst;
    logic [W-1:0]    clk_freq;
    logic [N_CH-1:0] req;
    logic [W-1:0]    pf_a [N_CH];
    logic [15:0]     du_a [N_CH];

    int n_tests;
    int n_fail;

    pwm_cfg_scheduler_if #(.N_CH(N_CH), .W(W)) bus ();

    assign bus.clk_freq = clk_freq;
    assign bus.req      = req;
    for (genvar g = 0; g < N_CH; g++) begin : g_in
        assign bus.pwm_freq[g*W +: W] = pf_a[g];
        assign bus.duty[g*16 +: 16]   = du_a[g];
    end

    pwm_cfg_scheduler #(.N_CH(N_CH), .W(W), .DEF_WIDTH(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: one operation at a time, fixed latency
    logic [W-1:0]    m_hw [N_CH];
    logic [W-1:0]    m_lw [N_CH];
    logic [N_CH-1:0] m_ack, m_err, m_upd;
    bit              m_act;
    int              m_rr, m_g, m_n, m_end;
    bit              m_bad;
    logic [W-1:0]    m_h, m_l;

    task automatic model_reset();
        m_act = 0;
        m_rr  = N_CH - 1;
        m_ack = '0;
        m_err = '0;
        m_upd = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_hw[i] = DEF;
            m_lw[i] = DEF;
        end
    endtask

    // One clock edge of the model, using the inputs held across that edge
    task automatic model_step();
        longint unsigned cyc;
        bit found;
        int c;
        m_ack = '0;
        m_err = '0;
        m_upd = '0;
        if (!m_act) begin
            found = 0;
            for (int k = 1; k <= N_CH; k++) begin
                c = (m_rr + k) % N_CH;
                if (!found && req[c]) begin
                    found = 1;
                    m_g   = c;
                end
            end
            if (found) begin
                m_act = 1;
                m_n   = 0;
            end
        end else begin
            m_n++;
            if (m_n == 1) begin
                if (pf_a[m_g] == 0) begin
                    m_bad = 1;
                    m_end = 1;
                end else begin
                    cyc   = longint'(clk_freq) / longint'(pf_a[m_g]);
                    m_bad = (cyc == 0);
                    m_h   = W'((cyc * longint'(du_a[m_g])) >> 16);
                    m_l   = W'(cyc) - m_h;
                    m_end = W + 2;
                end
            end
            if (m_n == m_end) begin
                m_ack[m_g] = 1'b1;
                if (m_bad) begin
                    m_err[m_g] = 1'b1;
                end else begin
                    m_upd[m_g] = 1'b1;
                    m_hw[m_g]  = m_h;
                    m_lw[m_g]  = m_l;
                end
            end else if (m_n == m_end + 1) begin
                m_act = 0;
                m_rr  = m_g;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("ack", 64'(bus.ack), 64'(m_ack));
        chk("err", 64'(bus.err), 64'(m_err));
        chk("upd", 64'(bus.upd), 64'(m_upd));
        chk("busy", 64'(bus.busy), 64'(m_act));
        for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("high_width%0d", i),
                64'(bus.high_width[i*W +: W]), 64'(m_hw[i]));
            chk($sformatf("low_width%0d", i),
                64'(bus.low_width[i*W +: W]), 64'(m_lw[i]));
        end
    endtask

    // Advance one cycle: step the model, compare, then leave room to drive
    task automatic tick();
        @(negedge clk);
        if (!rst) model_reset();
        else      model_step();
        compare_all();
        #1;
    endtask

    task automatic wait_ack(input int ch, input int n0, input int exp_lat,
                            input logic exp_err, input logic [W-1:0] eh,
                            input logic [W-1:0] el);
        int n;
        bit seen;
        n    = n0;
        seen = 0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (bus.ack[ch]) seen = 1;
        end
        req[ch] = 1'b0;
        chk($sformatf("ack_latency_ch%0d", ch), 64'(n), 64'(exp_lat));
        chk($sformatf("err_ch%0d", ch), 64'(bus.err[ch]), 64'(exp_err));
        chk($sformatf("upd_ch%0d", ch), 64'(bus.upd[ch]), 64'(!exp_err));
        chk($sformatf("lit_high%0d", ch), 64'(bus.high_width[ch*W +: W]), 64'(eh));
        chk($sformatf("lit_low%0d", ch), 64'(bus.low_width[ch*W +: W]), 64'(el));
        tick();
    endtask

    task automatic run_req(input int ch, input logic [W-1:0] cf,
                           input logic [W-1:0] pf, input logic [15:0] d,
                           input int exp_lat, input logic exp_err,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
        clk_freq = cf;
        pf_a[ch] = pf;
        du_a[ch] = d;
        req[ch]  = 1'b1;
        wait_ack(ch, 0, exp_lat, exp_err, eh, el);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk("drain_idle", 64'(bus.busy), 64'd0);
        tick();
    endtask

    function automatic logic [W-1:0] rnd_pf();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'($urandom);
            default: return W'($urandom_range(1, 5000));
        endcase
    endfunction

    function automatic logic [15:0] rnd_duty();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, last, idx;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        req      = '0;
        clk_freq = '0;
        for (int i = 0; i < N_CH; i++) begin
            pf_a[i] = '0;
            du_a[i] = '0;
        end
        repeat (3) tick();
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_ack", 64'(bus.ack), 64'd0);
        chk("reset_high0", 64'(bus.high_width[0 +: W]), 64'd100);
        rst = 1'b1;
        tick();

        run_req(0, 100000, 1000, 16'h8000, 35, 1'b0, 50, 50);
        for (int i = 1; i < N_CH; i++) begin
            chk($sformatf("untouched_high%0d", i),
                64'(bus.high_width[i*W +: W]), 64'd100);
            chk($sformatf("untouched_low%0d", i),
                64'(bus.low_width[i*W +: W]), 64'd100);
        end

        run_req(1, 100000, 1000, 16'hFFFF, 35, 1'b0, 99, 1);
        run_req(1, 100000, 1000, 16'h0000, 35, 1'b0, 0, 100);

        run_req(2, 100000, 0, 16'h8000, 2, 1'b1, 100, 100);
        run_req(2, 500, 1000, 16'h8000, 35, 1'b1, 100, 100);

        rst      = 1'b0;
        req      = '1;
        clk_freq = 100000;
        for (int i = 0; i < N_CH; i++) begin
            pf_a[i] = W'(1000 * (i + 1));
            du_a[i] = 16'h8000;
        end
        tick();
        rst  = 1'b1;
        n    = 0;
        k    = 0;
        last = 0;
        while (k < 8 && n < 400) begin
            tick();
            n++;
            if (bus.ack != '0) begin
                idx = -1;
                for (int i = 0; i < N_CH; i++) if (bus.ack[i]) idx = i;
                chk("rr_order", 64'(idx), 64'(k % N_CH));
                if (k == 0) chk("rr_first_latency", 64'(n), 64'd35);
                else        chk("rr_gap", 64'(n - last), 64'd36);
                last = n;
                k++;
            end
        end
        chk("rr_ack_count", 64'(k), 64'd8);
        req = '0;
        wait_idle();

        clk_freq = 100000;
        pf_a[3]  = 2000;
        du_a[3]  = 16'h4000;
        req[3]   = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("abort_ack", 64'(bus.ack), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("abort_high%0d", i),
                64'(bus.high_width[i*W +: W]), 64'd100);
            chk($sformatf("abort_low%0d", i),
                64'(bus.low_width[i*W +: W]), 64'd100);
        end
        tick();
        rst = 1'b1;
        wait_ack(3, 0, 35, 1'b0, 12, 38);

        clk_freq = 100000;
        pf_a[0]  = 1000;
        du_a[0]  = 16'h8000;
        req[0]   = 1'b1;
        tick();
        chk("latch_busy", 64'(bus.busy), 64'd1);
        tick();
        du_a[0] = 16'hFFFF;
        req[0]  = 1'b0;
        wait_ack(0, 2, 35, 1'b0, 50, 50);

        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (req[c] && bus.ack[c]) begin
                    if ($urandom_range(0, 1) == 0) req[c] = 1'b0;
                end else if (!req[c]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        pf_a[c] = rnd_pf();
                        du_a[c] = rnd_duty();
                        req[c]  = 1'b1;
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    req[c] = 1'b0;
                end
                if ($urandom_range(0, 31) == 0) du_a[c] = rnd_duty();
            end
            if ($urandom_range(0, 31) == 0)
                clk_freq = W'($urandom_range(0, 300000));
            if (t == 1500) rst = 1'b0;
            if (t == 1502) rst = 1'b1;
            tick();
        end
        req = '0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
